// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the MixColumns datapath: state/column
// typedefs, byte/column slice helpers, GF(2^8) multipliers, and the FSM encoding.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_fsm_e;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] GF_RED = 8'h1B;

    // MSB position of byte k; byte 0 sits at the top of the state.
    function automatic logic [6:0] byte_msb(logic [3:0] k);
        return 7'd127 - {k, 3'd0};
    endfunction

    // MSB position of column c; column c holds bytes 4c..4c+3.
    function automatic logic [6:0] col_msb(logic [1:0] c);
        return 7'd127 - {c, 5'd0};
    endfunction

    function automatic aes_col_t get_col(aes_state_t s, logic [1:0] c);
        return s[col_msb(c) -: 32];
    endfunction

    function automatic aes_state_t set_col(aes_state_t s, logic [1:0] c, aes_col_t v);
        aes_state_t r;
        r = s;
        r[col_msb(c) -: 32] = v;
        return r;
    endfunction

    // Multiply by x, reducing modulo the field polynomial.
    function automatic logic [7:0] gf_x2(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    function automatic logic [7:0] gf_x3(logic [7:0] a);
        return gf_x2(a) ^ a;
    endfunction

endpackage

// File: rtl/mixcol_column.sv
// Combinational transform of one 32-bit column. The inverse reuses the
// forward network after a cheap pre-mix with 4*(a0^a2) / 4*(a1^a3).
module mixcol_column
    import aes_pkg::*;
(
    input  aes_col_t col_i,
    input  logic     inv_i,
    output aes_col_t col_o
);

    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [7:0] r [4];
    logic [7:0] u;
    logic [7:0] v;

    // Split the column into rows, apply the optional inverse pre-mix.
    always_comb begin
        a[0] = col_i[31:24];
        a[1] = col_i[23:16];
        a[2] = col_i[15:8];
        a[3] = col_i[7:0];
        u = gf_x2(gf_x2(a[0] ^ a[2]));
        v = gf_x2(gf_x2(a[1] ^ a[3]));
        if (inv_i) begin
            b[0] = a[0] ^ u;
            b[1] = a[1] ^ v;
            b[2] = a[2] ^ u;
            b[3] = a[3] ^ v;
        end else begin
            b[0] = a[0];
            b[1] = a[1];
            b[2] = a[2];
            b[3] = a[3];
        end
    end

    // Forward MixColumns on the (possibly pre-mixed) column.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            r[i] = gf_x2(b[i]) ^ gf_x3(b[(i + 1) % 4]) ^ b[(i + 2) % 4] ^ b[(i + 3) % 4];
        end
    end

    assign col_o = {r[0], r[1], r[2], r[3]};

endmodule

// File: rtl/mixcol_seq.sv
// Sequential (Inv)MixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per busy cycle in place, then holds the result until
// downstream takes it.
module mixcol_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_inv,
    input  logic [127:0] i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_state,
    output logic         o_busy
);

    // Any width outside {1,2,4} would leave columns untouched or wrap.
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] CNT_STEP = 3'(COLS_PER_CYCLE);
    localparam logic [2:0] CNT_LAST = 3'(4 - COLS_PER_CYCLE);

    mc_fsm_e    state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    aes_state_t work_q, work_d;
    logic       inv_q, inv_d;

    aes_col_t col_in  [COLS_PER_CYCLE];
    aes_col_t col_out [COLS_PER_CYCLE];

    // One column transformer per column handled in a busy cycle.
    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            assign col_in[g] = get_col(work_q, cnt_q[1:0] + 2'(g));
            mixcol_column u_col (
                .col_i (col_in[g]),
                .inv_i (inv_q),
                .col_o (col_out[g])
            );
        end
    endgenerate

    // Next-state: load in IDLE, write back column group in BUSY, wait in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    work_d  = i_state;
                    inv_d   = i_inv;
                    cnt_d   = 3'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    work_d = set_col(work_d, cnt_q[1:0] + 2'(g), col_out[g]);
                end
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            work_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_busy  = (state_q == ST_BUSY) || (state_q == ST_DONE);
    assign o_state = work_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed bench for mixcol_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mixcol_seq;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic         in_inv    [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_ready [3];
    logic         out_valid [3];
    logic         out_busy  [3];
    logic [127:0] out_state [3];

    int checks = 0;
    int errors = 0;
    int nsteps [3] = '{4, 2, 1};

    mixcol_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
        .i_inv(in_inv[0]), .i_state(in_state[0]), .o_valid(out_valid[0]),
        .i_ready(in_ready[0]), .o_state(out_state[0]), .o_busy(out_busy[0]));
    mixcol_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
        .i_inv(in_inv[1]), .i_state(in_state[1]), .o_valid(out_valid[1]),
        .i_ready(in_ready[1]), .o_state(out_state[1]), .o_busy(out_busy[1]));
    mixcol_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid[2]), .o_ready(out_ready[2]),
        .i_inv(in_inv[2]), .i_state(in_state[2]), .o_valid(out_valid[2]),
        .i_ready(in_ready[2]), .o_state(out_state[2]), .o_busy(out_busy[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One block through instance d; entered and left at #1 after a rising edge.
    task automatic run(input int d, input logic [127:0] st, input logic inv,
                       input logic [127:0] exp, input int hold, input bit noise);
        string t;
        t = $sformatf("%s/d%0d", inv ? "inv" : "fwd", d);
        in_valid[d] = 1'b1;
        in_state[d] = st;
        in_inv[d]   = inv;
        in_ready[d] = 1'b0;
        chk({t, " ready_before"}, out_ready[d], 1);
        @(posedge clk); #1;
        if (noise) begin
            in_state[d] = ~st;
            in_inv[d]   = ~inv;
        end else begin
            in_valid[d] = 1'b0;
        end
        repeat (nsteps[d]) begin
            chk({t, " valid_busy"}, {out_valid[d], out_busy[d], out_ready[d]}, 3'b010);
            @(posedge clk); #1;
        end
        chk({t, " valid_done"}, out_valid[d], 1);
        chk({t, " state"}, out_state[d], exp);
        repeat (hold) begin
            @(posedge clk); #1;
            chk({t, " hold_valid"}, out_valid[d], 1);
            chk({t, " hold_state"}, out_state[d], exp);
        end
        in_valid[d] = 1'b0;
        in_ready[d] = 1'b1;
        @(posedge clk); #1;
        chk({t, " idle_flags"}, {out_valid[d], out_busy[d], out_ready[d]}, 3'b001);
        chk({t, " idle_state"}, out_state[d], exp);
        in_ready[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0;
            in_inv[d]   = 1'b0;
            in_ready[d] = 1'b0;
            in_state[d] = '0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_state/d%0d", d), out_state[d], 0);
            chk($sformatf("reset_flags/d%0d", d), {out_valid[d], out_busy[d], out_ready[d]}, 3'b001);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors at every width.
        for (int d = 0; d < 3; d++) begin
            run(d, FWD_IN, 1'b0, FWD_OUT, 0, 1'b0);
            run(d, INV_IN, 1'b1, INV_OUT, 0, 1'b0);
        end

        // Backpressure with input noise during BUSY and DONE.
        run(0, FWD_IN, 1'b0, FWD_OUT, 10, 1'b1);
        run(2, INV_IN, 1'b1, INV_OUT, 10, 1'b1);

        // Back-to-back at COLS_PER_CYCLE=2: accept every 4 cycles.
        in_valid[1] = 1'b1; in_ready[1] = 1'b1;
        in_state[1] = FWD_IN; in_inv[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b busy_a", out_busy[1], 1);
        in_state[1] = INV_IN; in_inv[1] = 1'b1;
        @(posedge clk); #1;
        chk("b2b notvalid_a", out_valid[1], 0);
        @(posedge clk); #1;
        chk("b2b valid_a", out_valid[1], 1);
        chk("b2b state_a", out_state[1], FWD_OUT);
        @(posedge clk); #1;
        chk("b2b idle_ready", out_ready[1], 1);
        chk("b2b idle_state", out_state[1], FWD_OUT);
        @(posedge clk); #1;
        chk("b2b accept_b", {out_busy[1], out_ready[1]}, 2'b10);
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b notvalid_b", out_valid[1], 0);
        @(posedge clk); #1;
        chk("b2b valid_b", out_valid[1], 1);
        chk("b2b state_b", out_state[1], INV_OUT);
        @(posedge clk); #1;
        chk("b2b end_flags", {out_valid[1], out_busy[1], out_ready[1]}, 3'b001);
        in_ready[1] = 1'b0;

        // Reset during the second busy cycle at COLS_PER_CYCLE=1.
        in_valid[0] = 1'b1; in_state[0] = FWD_IN; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst busy", out_busy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst state", out_state[0], 0);
        chk("mid_rst flags", {out_valid[0], out_busy[0], out_ready[0]}, 3'b001);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_rst flags", {out_valid[0], out_busy[0], out_ready[0]}, 3'b001);
            chk("post_rst state", out_state[0], 0);
        end
        run(0, INV_IN, 1'b1, INV_OUT, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
